// File: rtl/vec_dot_engine.sv
// ----------------------------------------------------------------------------
// vec_dot_engine
//
// Multi-lane integer dot-product engine. On an accepted start the operand
// vectors and the signed/unsigned mode are latched; LANES element products
// are then accumulated per clock over VEC_LEN elements. The full-precision
// sum is reduced to OUT_W bits and an overflow flag reports whether it fit.
//
// Parameters:
//   DATA_W   element width of a and b
//   VEC_LEN  elements per vector (multiple of LANES)
//   LANES    products accumulated per clock (>= 1, divides VEC_LEN)
//   OUT_W    result width (<= 2*DATA_W + clog2(VEC_LEN))
//
// Ports:
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   start        request, sampled only when idle
//   signed_mode  1 = two's-complement operands, 0 = unsigned (latched)
//   a, b         flat operand vectors, element k at [k*DATA_W +: DATA_W]
//   c            result, held until the next result is produced
//   ovf          sum outside OUT_W range for the latched mode
//   busy         high from accept edge until result edge
//   done         one-cycle pulse when c/ovf are valid
//
// Build option:
//   DOT_SATURATE_EN  defined: out-of-range sums clamp c to the mode's
//                    max/min. Undefined: c takes the low OUT_W bits.
// ----------------------------------------------------------------------------
module vec_dot_engine #(
    parameter int DATA_W  = 8,
    parameter int VEC_LEN = 16,
    parameter int LANES   = 2,
    parameter int OUT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      signed_mode,
    input  logic [VEC_LEN*DATA_W-1:0] a,
    input  logic [VEC_LEN*DATA_W-1:0] b,
    output logic [OUT_W-1:0]          c,
    output logic                      ovf,
    output logic                      busy,
    output logic                      done
);

    localparam int ACC_W  = 2*DATA_W + $clog2(VEC_LEN);
    localparam int N_GRP  = VEC_LEN / LANES;
    localparam int GRP_W  = (N_GRP > 1) ? $clog2(N_GRP) : 1;
    localparam int PROD_W = 2*DATA_W + 2;
    localparam int STEP   = LANES * DATA_W;
    localparam int VEC_W  = VEC_LEN * DATA_W;

    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(N_GRP - 1);

    // Range limits held one bit wider than the accumulator so both the
    // unsigned and the sign-extended signed interpretation compare cleanly.
    localparam logic [ACC_W:0] ONE   = {{ACC_W{1'b0}}, 1'b1};
    localparam logic [ACC_W:0] U_LIM = ONE << OUT_W;
    localparam logic [ACC_W:0] S_MAX = (ONE << (OUT_W - 1)) - ONE;
    localparam logic [ACC_W:0] S_MIN = ~(ONE << (OUT_W - 1)) + ONE;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t             state;
    logic [VEC_W-1:0]   a_q;
    logic [VEC_W-1:0]   b_q;
    logic               mode_q;
    logic [ACC_W-1:0]   acc;
    logic [GRP_W-1:0]   grp;

    logic signed [DATA_W:0]   ea;
    logic signed [DATA_W:0]   eb;
    logic signed [PROD_W-1:0] prod;
    logic [ACC_W-1:0]         lane_sum;
    logic [ACC_W-1:0]         acc_next;
    logic [ACC_W:0]           fin_x;
    logic                     u_over;
    logic                     s_hi;
    logic                     s_lo;
    logic                     ovf_next;
    logic [OUT_W-1:0]         c_next;

    // The latched vectors shift down by one lane group per cycle, so the
    // current group always sits in the low STEP bits.
    // Each element is widened by one bit (sign or zero) so a single signed
    // multiply serves both modes.
    always_comb begin
        lane_sum = '0;
        ea       = '0;
        eb       = '0;
        prod     = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            ea       = {mode_q & a_q[l*DATA_W + DATA_W - 1], a_q[l*DATA_W +: DATA_W]};
            eb       = {mode_q & b_q[l*DATA_W + DATA_W - 1], b_q[l*DATA_W +: DATA_W]};
            prod     = ea * eb;
            lane_sum = lane_sum + ACC_W'(prod);
        end
    end

    assign acc_next = acc + lane_sum;

    always_comb begin
        fin_x    = mode_q ? {acc_next[ACC_W-1], acc_next} : {1'b0, acc_next};
        u_over   = (fin_x >= U_LIM);
        s_hi     = ($signed(fin_x) > $signed(S_MAX));
        s_lo     = ($signed(fin_x) < $signed(S_MIN));
        ovf_next = mode_q ? (s_hi | s_lo) : u_over;
`ifdef DOT_SATURATE_EN
        if (!mode_q && u_over)
            c_next = '1;
        else if (mode_q && s_hi)
            c_next = {1'b0, {(OUT_W-1){1'b1}}};
        else if (mode_q && s_lo)
            c_next = {1'b1, {(OUT_W-1){1'b0}}};
        else
            c_next = acc_next[OUT_W-1:0];
`else
        c_next = acc_next[OUT_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            acc    <= '0;
            grp    <= '0;
            c      <= '0;
            ovf    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= ACCUM;
                        a_q    <= a;
                        b_q    <= b;
                        mode_q <= signed_mode;
                        acc    <= '0;
                        grp    <= '0;
                        busy   <= 1'b1;
                    end
                end
                ACCUM: begin
                    acc <= acc_next;
                    a_q <= a_q >> STEP;
                    b_q <= b_q >> STEP;
                    grp <= grp + GRP_W'(1);
                    if (grp == LAST_GRP) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        c     <= c_next;
                        ovf   <= ovf_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_dot_engine.sv
// ----------------------------------------------------------------------------
// tb_vec_dot_engine
//
// Three engines (LANES = 2, 1, 4) share operands, mode and reset; each has
// its own start. Directed table vectors, hand-written multi-cycle sequences
// and randomized operations are checked against an arithmetic model.
// ----------------------------------------------------------------------------
module tb_vec_dot_engine;

    localparam int DW = 8;
    localparam int VL = 16;
    localparam int OW = 16;
    localparam int VW = VL * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mode;
    logic [VW-1:0] a;
    logic [VW-1:0] b;
    logic          start_v [3];
    logic [OW-1:0] c_v     [3];
    logic          ovf_v   [3];
    logic          busy_v  [3];
    logic          done_v  [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vec_dot_engine #(.DATA_W(DW), .VEC_LEN(VL), .LANES(2), .OUT_W(OW)) u_l2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .signed_mode(mode),
        .a(a), .b(b), .c(c_v[0]), .ovf(ovf_v[0]), .busy(busy_v[0]), .done(done_v[0]));

    vec_dot_engine #(.DATA_W(DW), .VEC_LEN(VL), .LANES(1), .OUT_W(OW)) u_l1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .signed_mode(mode),
        .a(a), .b(b), .c(c_v[1]), .ovf(ovf_v[1]), .busy(busy_v[1]), .done(done_v[1]));

    vec_dot_engine #(.DATA_W(DW), .VEC_LEN(VL), .LANES(4), .OUT_W(OW)) u_l4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .signed_mode(mode),
        .a(a), .b(b), .c(c_v[2]), .ovf(ovf_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    typedef struct {
        logic [VW-1:0] av;
        logic [VW-1:0] bv;
        logic          sm;
        logic [OW-1:0] ec;
        logic          eo;
    } vec_t;

    vec_t tbl [9];

    function automatic int lat_of(input int d);
        case (d)
            0:       return VL / 2;
            1:       return VL / 1;
            default: return VL / 4;
        endcase
    endfunction

    function automatic logic [VW-1:0] fill(input logic [7:0] x);
        return {VL{x}};
    endfunction

    function automatic logic [VW-1:0] put(input logic [VW-1:0] v, input int k, input logic [7:0] x);
        logic [VW-1:0] r;
        r = v;
        r[k*DW +: DW] = x;
        return r;
    endfunction

    function automatic logic [7:0] rbyte();
        case ($urandom_range(0, 4))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'h80;
            3:       return 8'h7F;
            default: return 8'($urandom);
        endcase
    endfunction

    // Plain integer dot product, then range rules on the full sum.
    function automatic void model(input logic [VW-1:0] av, input logic [VW-1:0] bv,
                                  input logic sm, output logic [OW-1:0] ec, output logic eo);
        longint        s;
        longint        x;
        longint        y;
        logic [7:0]    ae;
        logic [7:0]    be;
        logic [63:0]   sb;
        s = 0;
        for (int k = 0; k < VL; k++) begin
            ae = av[k*DW +: DW];
            be = bv[k*DW +: DW];
            x  = sm ? longint'($signed(ae)) : longint'(ae);
            y  = sm ? longint'($signed(be)) : longint'(be);
            s  = s + x * y;
        end
        if (sm)
            eo = (s < -32768) || (s > 32767);
        else
            eo = (s > 65535);
        sb = s;
        ec = sb[15:0];
`ifdef DOT_SATURATE_EN
        if (eo)
            ec = sm ? ((s > 0) ? 16'h7FFF : 16'h8000) : 16'hFFFF;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called just after the accept edge; returns edges until done is seen.
    task automatic wait_done(input int d, input int budget, output int lat);
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk);
            #1;
            if (done_v[d]) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input int d, input logic [VW-1:0] av, input logic [VW-1:0] bv,
                          input logic sm, input logic [OW-1:0] ec, input logic eo,
                          input string tag);
        int lat;
        a = av;
        b = bv;
        mode = sm;
        start_v[d] = 1'b1;
        @(posedge clk);
        #1;
        start_v[d] = 1'b0;
        a = ~av;
        b = ~bv;
        mode = ~sm;
        chk($sformatf("%s busy_after_accept d%0d", tag, d), 32'(busy_v[d]), 32'd1);
        wait_done(d, 40, lat);
        chk($sformatf("%s latency d%0d", tag, d), 32'(lat), 32'(lat_of(d)));
        chk($sformatf("%s c d%0d", tag, d), 32'(c_v[d]), 32'(ec));
        chk($sformatf("%s ovf d%0d", tag, d), 32'(ovf_v[d]), 32'(eo));
        chk($sformatf("%s busy_at_done d%0d", tag, d), 32'(busy_v[d]), 32'd0);
        @(posedge clk);
        #1;
        chk($sformatf("%s done_pulse_width d%0d", tag, d), 32'(done_v[d]), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] ra;
        logic [VW-1:0] rb;
        logic          rs;
        logic [OW-1:0] ec;
        logic          eo;
        int            lat;
        int            rd;
        logic          seen;

        tbl[0] = '{fill(8'h01), fill(8'h02), 1'b0, 16'h0020, 1'b0};
        tbl[1] = '{fill(8'hFF), fill(8'h7F), 1'b1, 16'hF810, 1'b0};
`ifdef DOT_SATURATE_EN
        tbl[2] = '{fill(8'hFF), fill(8'hFF), 1'b0, 16'hFFFF, 1'b1};
        tbl[3] = '{fill(8'h80), fill(8'h80), 1'b1, 16'h7FFF, 1'b1};
        tbl[6] = '{put(put('0, 0, 8'h80), 1, 8'h80), put(put('0, 0, 8'h80), 1, 8'h80),
                   1'b1, 16'h7FFF, 1'b1};
        tbl[8] = '{put(put(put('0, 0, 8'hFF), 1, 8'hFF), 2, 8'h01),
                   put(put(put('0, 0, 8'hFF), 1, 8'h02), 2, 8'h01), 1'b0, 16'hFFFF, 1'b1};
`else
        tbl[2] = '{fill(8'hFF), fill(8'hFF), 1'b0, 16'hE010, 1'b1};
        tbl[3] = '{fill(8'h80), fill(8'h80), 1'b1, 16'h0000, 1'b1};
        tbl[6] = '{put(put('0, 0, 8'h80), 1, 8'h80), put(put('0, 0, 8'h80), 1, 8'h80),
                   1'b1, 16'h8000, 1'b1};
        tbl[8] = '{put(put(put('0, 0, 8'hFF), 1, 8'hFF), 2, 8'h01),
                   put(put(put('0, 0, 8'hFF), 1, 8'h02), 2, 8'h01), 1'b0, 16'h0000, 1'b1};
`endif
        tbl[4] = '{'0, '0, 1'b1, 16'h0000, 1'b0};
        // -128*127 + -128*127 + -128*2 = -32768, the signed minimum
        tbl[5] = '{put(put(put('0, 0, 8'h80), 1, 8'h80), 2, 8'h80),
                   put(put(put('0, 0, 8'h7F), 1, 8'h7F), 2, 8'h02), 1'b1, 16'h8000, 1'b0};
        // 255*255 + 255*2 = 65535, the unsigned maximum
        tbl[7] = '{put(put('0, 0, 8'hFF), 1, 8'hFF), put(put('0, 0, 8'hFF), 1, 8'h02),
                   1'b0, 16'hFFFF, 1'b0};

        rst_n = 1'b0;
        mode  = 1'b0;
        a     = '0;
        b     = '0;
        for (int d = 0; d < 3; d++) start_v[d] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset c d%0d", d), 32'(c_v[d]), 32'd0);
            chk($sformatf("reset ovf d%0d", d), 32'(ovf_v[d]), 32'd0);
            chk($sformatf("reset busy d%0d", d), 32'(busy_v[d]), 32'd0);
            chk($sformatf("reset done d%0d", d), 32'(done_v[d]), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table on every lane configuration
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 9; i++)
                run_op(d, tbl[i].av, tbl[i].bv, tbl[i].sm, tbl[i].ec, tbl[i].eo,
                       $sformatf("tbl%0d", i));

        // Operand churn and a start pulse mid-run have no effect
        a = fill(8'h01);
        b = fill(8'h02);
        mode = 1'b0;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        a = fill(8'h55);
        b = fill(8'hAA);
        mode = 1'b1;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        wait_done(0, 20, lat);
        chk("midrun latency", 32'(lat), 32'd4);
        chk("midrun c", 32'(c_v[0]), 32'h0020);
        chk("midrun ovf", 32'(ovf_v[0]), 32'd0);
        @(posedge clk);
        #1;
        chk("midrun start_not_queued", 32'(busy_v[0]), 32'd0);

        // Start held high: second run accepted in the done cycle
        a = fill(8'h01);
        b = fill(8'h02);
        mode = 1'b0;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        wait_done(0, 20, lat);
        chk("b2b first latency", 32'(lat), 32'd8);
        wait_done(0, 20, lat);
        start_v[0] = 1'b0;
        chk("b2b second spacing", 32'(lat), 32'd9);
        chk("b2b second c", 32'(c_v[0]), 32'h0020);
        @(posedge clk);
        #1;
        chk("b2b no third run", 32'(busy_v[0]), 32'd0);

        // Reset mid-run on each lane configuration, then a normal run
        for (int d = 0; d < 3; d++) begin
            run_op(d, fill(8'h01), fill(8'h02), 1'b0, 16'h0020, 1'b0, "pre_rst");
            a = fill(8'hFF);
            b = fill(8'hFF);
            mode = 1'b0;
            start_v[d] = 1'b1;
            @(posedge clk);
            #1;
            start_v[d] = 1'b0;
            repeat (3) begin
                @(posedge clk);
                #1;
            end
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            chk($sformatf("midrst c d%0d", d), 32'(c_v[d]), 32'd0);
            chk($sformatf("midrst ovf d%0d", d), 32'(ovf_v[d]), 32'd0);
            chk($sformatf("midrst busy d%0d", d), 32'(busy_v[d]), 32'd0);
            seen = 1'b0;
            for (int k = 0; k < lat_of(d) + 4; k++) begin
                if (done_v[d]) seen = 1'b1;
                @(posedge clk);
                #1;
            end
            chk($sformatf("midrst no_done d%0d", d), 32'(seen), 32'd0);
            run_op(d, fill(8'hFF), fill(8'h7F), 1'b1, 16'hF810, 1'b0, "post_rst");
        end

        // Randomized operations against the arithmetic model
        for (int i = 0; i < 60; i++) begin
            for (int k = 0; k < VL; k++) begin
                ra[k*DW +: DW] = rbyte();
                rb[k*DW +: DW] = rbyte();
            end
            rs = 1'($urandom_range(0, 1));
            rd = $urandom_range(0, 2);
            model(ra, rb, rs, ec, eo);
            run_op(rd, ra, rb, rs, ec, eo, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
